// File: rtl/l1_mem_arbiter_if.sv
// rtl/l1_mem_arbiter_if.sv - L1D/L1I request, response and memory-port signal bundle
interface l1_mem_arbiter_if #(
  parameter int M_WIDTH  = 32,
  parameter int CL_BITS  = 128,
  parameter int TAG_BITS = 2
);
  logic                l1d_req_valid;
  logic [M_WIDTH-1:0]  l1d_req_addr;
  logic [CL_BITS-1:0]  l1d_req_store_data;
  logic [TAG_BITS-1:0] l1d_req_tag;
  logic [3:0]          l1d_req_opcode;
  logic                l1d_req_ack;
  logic                l1d_rsp_valid;

  logic                l1i_req_valid;
  logic [M_WIDTH-1:0]  l1i_req_addr;
  logic [TAG_BITS-1:0] l1i_req_tag;
  logic [3:0]          l1i_req_opcode;
  logic                l1i_req_ack;
  logic                l1i_rsp_valid;

  logic                mem_req_valid;
  logic [M_WIDTH-1:0]  mem_req_addr;
  logic [CL_BITS-1:0]  mem_req_store_data;
  logic [TAG_BITS-1:0] mem_req_tag;
  logic [3:0]          mem_req_opcode;
  logic                mem_rsp_valid;

  logic                grant_hold;
  logic                idle;
  logic                timeout_err;
  logic                spurious_rsp_err;
  logic [63:0]         l1d_gnt_count;
  logic [63:0]         l1i_gnt_count;

  // Arbiter side
  modport slave (
    input  l1d_req_valid, l1d_req_addr, l1d_req_store_data, l1d_req_tag, l1d_req_opcode,
    output l1d_req_ack, l1d_rsp_valid,
    input  l1i_req_valid, l1i_req_addr, l1i_req_tag, l1i_req_opcode,
    output l1i_req_ack, l1i_rsp_valid,
    output mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag, mem_req_opcode,
    input  mem_rsp_valid,
    input  grant_hold,
    output idle, timeout_err, spurious_rsp_err, l1d_gnt_count, l1i_gnt_count
  );

  // Requester / memory side
  modport master (
    output l1d_req_valid, l1d_req_addr, l1d_req_store_data, l1d_req_tag, l1d_req_opcode,
    input  l1d_req_ack, l1d_rsp_valid,
    output l1i_req_valid, l1i_req_addr, l1i_req_tag, l1i_req_opcode,
    input  l1i_req_ack, l1i_rsp_valid,
    input  mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag, mem_req_opcode,
    output mem_rsp_valid,
    output grant_hold,
    input  idle, timeout_err, spurious_rsp_err, l1d_gnt_count, l1i_gnt_count
  );
endinterface

// File: rtl/l1_mem_arbiter.sv
// rtl/l1_mem_arbiter.sv - Two-requester round-robin arbiter for the single off-core memory port
// One transaction in flight; grant-hold, response watchdog, sticky errors, grant counters.
module l1_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            reset,
  l1_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } state_t;

  localparam bit              WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam int unsigned     WD_W     = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

  state_t          state;
  state_t          state_next;
  logic            grant_d;
  logic            grant_i;
  logic            last_gnt_i;
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A tie goes to whichever requester did not win the previous grant.
  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.grant_hold) begin
          if (bus.l1d_req_valid && (!bus.l1i_req_valid || last_gnt_i)) begin
            grant_d = 1'b1;
          end else if (bus.l1i_req_valid) begin
            grant_i = 1'b1;
          end
        end
        if (grant_d) begin
          state_next = BUSY_D;
        end else if (grant_i) begin
          state_next = BUSY_I;
        end
      end
      BUSY_D, BUSY_I: begin
        if (bus.mem_rsp_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.l1d_req_ack   = grant_d;
  assign bus.l1i_req_ack   = grant_i;
  assign bus.l1d_rsp_valid = (state == BUSY_D) && bus.mem_rsp_valid;
  assign bus.l1i_rsp_valid = (state == BUSY_I) && bus.mem_rsp_valid;
  assign bus.mem_req_valid = (state != IDLE);
  assign bus.idle          = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_req_addr       <= '0;
      bus.mem_req_store_data <= '0;
      bus.mem_req_tag        <= '0;
      bus.mem_req_opcode     <= '0;
      bus.l1d_gnt_count      <= '0;
      bus.l1i_gnt_count      <= '0;
      bus.timeout_err        <= 1'b0;
      bus.spurious_rsp_err   <= 1'b0;
      last_gnt_i             <= 1'b1;
      wd_cnt                 <= '0;
    end else begin
      if (grant_d) begin
        bus.mem_req_addr       <= bus.l1d_req_addr;
        bus.mem_req_store_data <= bus.l1d_req_store_data;
        bus.mem_req_tag        <= bus.l1d_req_tag;
        bus.mem_req_opcode     <= bus.l1d_req_opcode;
        bus.l1d_gnt_count      <= bus.l1d_gnt_count + 64'd1;
        last_gnt_i             <= 1'b0;
      end else if (grant_i) begin
        bus.mem_req_addr       <= bus.l1i_req_addr;
        bus.mem_req_store_data <= '0;
        bus.mem_req_tag        <= bus.l1i_req_tag;
        bus.mem_req_opcode     <= bus.l1i_req_opcode;
        bus.l1i_gnt_count      <= bus.l1i_gnt_count + 64'd1;
        last_gnt_i             <= 1'b1;
      end

      if ((state == IDLE) && bus.mem_rsp_valid) begin
        bus.spurious_rsp_err <= 1'b1;
      end

      // Watchdog saturates at the limit; the FSM keeps waiting for the response.
      if ((state == IDLE) || bus.mem_rsp_valid) begin
        wd_cnt <= '0;
      end else if (WD_EN && (wd_cnt != WD_LIMIT)) begin
        wd_cnt <= wd_cnt + WD_ONE;
        if ((wd_cnt + WD_ONE) == WD_LIMIT) begin
          bus.timeout_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb/tb_l1_mem_arbiter.sv - Directed and randomized bench for l1_mem_arbiter against a transaction-level model
module tb_l1_mem_arbiter;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l1_mem_arbiter_if #(.M_WIDTH(32), .CL_BITS(128), .TAG_BITS(2)) bus ();

  l1_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the port (0 none, 1 L1D, 2 L1I) and what was granted.
  int               owner;
  bit               last_i;
  longint unsigned  cnt_d, cnt_i;
  bit               to_err, sp_err;
  int               busy_n;
  logic [31:0]      m_addr;
  logic [127:0]     m_data;
  logic [1:0]       m_tag;
  logic [3:0]       m_op;
  int               grants[$];

  bit d_keep, i_keep, rnd;
  int rsp_mode, rsp_lat;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; last_i = 1'b1; cnt_d = 0; cnt_i = 0;
    to_err = 0; sp_err = 0; busy_n = 0;
    grants.delete();
  endtask

  task automatic new_d();
    bus.l1d_req_valid      = 1'b1;
    bus.l1d_req_addr       = $urandom;
    bus.l1d_req_store_data = {$urandom, $urandom, $urandom, $urandom};
    bus.l1d_req_tag        = 2'($urandom);
    bus.l1d_req_opcode     = 4'($urandom);
  endtask

  task automatic new_i();
    bus.l1i_req_valid  = 1'b1;
    bus.l1i_req_addr   = $urandom;
    bus.l1i_req_tag    = 2'($urandom);
    bus.l1i_req_opcode = 4'($urandom);
  endtask

  task automatic zero_inputs();
    bus.l1d_req_valid = 0; bus.l1d_req_addr = 0; bus.l1d_req_store_data = 0;
    bus.l1d_req_tag = 0; bus.l1d_req_opcode = 0;
    bus.l1i_req_valid = 0; bus.l1i_req_addr = 0; bus.l1i_req_tag = 0; bus.l1i_req_opcode = 0;
    bus.mem_rsp_valid = 0; bus.grant_hold = 0;
    d_keep = 0; i_keep = 0; rnd = 0; rsp_mode = 0; rsp_lat = 1;
  endtask

  task automatic do_reset();
    zero_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset();
    chk("rst_idle", bus.idle, 1'b1);
    chk("rst_mem_valid", bus.mem_req_valid, 1'b0);
    chk("rst_addr", bus.mem_req_addr, 32'd0);
    chk("rst_data", bus.mem_req_store_data, 128'd0);
    chk("rst_tag", bus.mem_req_tag, 2'd0);
    chk("rst_op", bus.mem_req_opcode, 4'd0);
    chk("rst_acks", {bus.l1d_req_ack, bus.l1i_req_ack}, 2'b00);
    chk("rst_rsps", {bus.l1d_rsp_valid, bus.l1i_rsp_valid}, 2'b00);
    chk("rst_errs", {bus.timeout_err, bus.spurious_rsp_err}, 2'b00);
    chk("rst_cnt_d", bus.l1d_gnt_count, 64'd0);
    chk("rst_cnt_i", bus.l1i_gnt_count, 64'd0);
  endtask

  // One clock: compare every output at the falling edge, advance the model,
  // then drive the next cycle's inputs just after the rising edge.
  task automatic tick();
    bit ed, ei, rsp;
    @(negedge clk);
    ed = 0; ei = 0;
    rsp = bus.mem_rsp_valid;
    if (owner == 0 && !bus.grant_hold) begin
      if (bus.l1d_req_valid && bus.l1i_req_valid) begin
        if (last_i) ed = 1; else ei = 1;
      end else if (bus.l1d_req_valid) ed = 1;
      else if (bus.l1i_req_valid) ei = 1;
    end
    chk("d_ack", bus.l1d_req_ack, ed);
    chk("i_ack", bus.l1i_req_ack, ei);
    chk("d_rsp", bus.l1d_rsp_valid, (owner == 1) && rsp);
    chk("i_rsp", bus.l1i_rsp_valid, (owner == 2) && rsp);
    chk("mem_valid", bus.mem_req_valid, owner != 0);
    chk("idle", bus.idle, owner == 0);
    if (owner != 0) begin
      chk("mem_addr", bus.mem_req_addr, m_addr);
      chk("mem_data", bus.mem_req_store_data, m_data);
      chk("mem_tag", bus.mem_req_tag, m_tag);
      chk("mem_op", bus.mem_req_opcode, m_op);
    end
    chk("cnt_d", bus.l1d_gnt_count, cnt_d);
    chk("cnt_i", bus.l1i_gnt_count, cnt_i);
    chk("timeout_err", bus.timeout_err, to_err);
    chk("spurious_err", bus.spurious_rsp_err, sp_err);

    if (owner != 0) begin
      if (rsp) owner = 0;
      else begin
        busy_n++;
        if (busy_n == TMO) to_err = 1;
      end
    end else begin
      if (rsp) sp_err = 1;
      if (ed) begin
        owner = 1; last_i = 0; cnt_d++; busy_n = 0; grants.push_back(1);
        m_addr = bus.l1d_req_addr; m_data = bus.l1d_req_store_data;
        m_tag = bus.l1d_req_tag; m_op = bus.l1d_req_opcode;
      end else if (ei) begin
        owner = 2; last_i = 1; cnt_i++; busy_n = 0; grants.push_back(2);
        m_addr = bus.l1i_req_addr; m_data = '0;
        m_tag = bus.l1i_req_tag; m_op = bus.l1i_req_opcode;
      end
    end

    @(posedge clk);
    #1;
    if (ed) begin if (d_keep) new_d(); else bus.l1d_req_valid = 0; end
    if (ei) begin if (i_keep) new_i(); else bus.l1i_req_valid = 0; end
    if (rnd) begin
      d_keep = $urandom_range(0, 1) == 1;
      i_keep = $urandom_range(0, 1) == 1;
      if (!bus.l1d_req_valid && $urandom_range(0, 2) == 0) new_d();
      if (!bus.l1i_req_valid && $urandom_range(0, 2) == 0) new_i();
      bus.grant_hold = ($urandom_range(0, 7) == 0);
    end
    case (rsp_mode)
      1: bus.mem_rsp_valid = (owner != 0) && (busy_n + 1 == rsp_lat);
      2: bus.mem_rsp_valid = (owner != 0) ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 15) == 0);
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset values
    do_reset();
    check_reset();

    // L1D-only: addr 0x1000, response 5 cycles after the grant
    new_d();
    bus.l1d_req_addr = 32'h1000;
    rsp_mode = 1; rsp_lat = 5;
    repeat (8) tick();
    chk("t1_grants", grants.size(), 1);
    chk("t1_cnt_d", bus.l1d_gnt_count, 64'd1);
    chk("t1_addr", bus.mem_req_addr, 32'h1000);

    // Both requesters held valid: alternate D,I,D,I
    do_reset();
    d_keep = 1; i_keep = 1;
    new_d(); new_i();
    rsp_mode = 1; rsp_lat = 2;
    for (int c = 0; c < 60; c++) begin
      if (grants.size() == 4 && owner == 0) break;
      tick();
    end
    bus.l1d_req_valid = 0; bus.l1i_req_valid = 0;
    tick();
    chk("t2_grants", grants.size(), 4);
    for (int g = 0; g < 4; g++) chk($sformatf("t2_order%0d", g), grants[g], (g % 2 == 0) ? 1 : 2);
    chk("t2_cnt_d", bus.l1d_gnt_count, 64'd2);
    chk("t2_cnt_i", bus.l1i_gnt_count, 64'd2);

    // grant_hold during BUSY_D with L1I pending
    do_reset();
    new_d();
    tick();
    new_i();
    bus.grant_hold = 1;
    repeat (2) tick();
    bus.mem_rsp_valid = 1;
    tick();
    bus.mem_rsp_valid = 0;
    repeat (3) tick();
    chk("t3_idle_held", bus.idle, 1'b1);
    chk("t3_cnt_i_held", bus.l1i_gnt_count, 64'd0);
    bus.grant_hold = 0;
    rsp_mode = 1; rsp_lat = 2;
    repeat (4) tick();
    chk("t3_grants", grants.size(), 2);
    chk("t3_second", grants[1], 2);
    chk("t3_cnt_i", bus.l1i_gnt_count, 64'd1);

    // Watchdog: no response for 8 BUSY cycles
    do_reset();
    new_d();
    tick();
    repeat (TMO - 1) tick();
    chk("t4_to_before", bus.timeout_err, 1'b0);
    tick();
    chk("t4_to_at", bus.timeout_err, 1'b1);
    repeat (3) tick();
    chk("t4_still_busy", bus.mem_req_valid, 1'b1);
    bus.mem_rsp_valid = 1;
    tick();
    bus.mem_rsp_valid = 0;
    tick();
    chk("t4_done_idle", bus.idle, 1'b1);
    chk("t4_to_sticky", bus.timeout_err, 1'b1);

    // Spurious response in IDLE
    do_reset();
    bus.mem_rsp_valid = 1;
    tick();
    bus.mem_rsp_valid = 0;
    tick();
    chk("t5_spurious", bus.spurious_rsp_err, 1'b1);

    // Reset two cycles into BUSY_I, then a late response and a fresh L1D grant
    do_reset();
    new_i();
    tick();
    repeat (2) tick();
    do_reset();
    check_reset();
    bus.mem_rsp_valid = 1;
    tick();
    bus.mem_rsp_valid = 0;
    chk("t6_late_spurious", bus.spurious_rsp_err, 1'b1);
    new_d();
    rsp_mode = 1; rsp_lat = 3;
    repeat (6) tick();
    chk("t6_cnt_d", bus.l1d_gnt_count, 64'd1);
    chk("t6_grants", grants.size(), 1);

    // Randomized traffic, holds, responses and spurious pulses
    do_reset();
    rnd = 1; rsp_mode = 2;
    repeat (800) tick();
    rnd = 0; bus.grant_hold = 0;
    bus.l1d_req_valid = 0; bus.l1i_req_valid = 0;
    rsp_mode = 1; rsp_lat = 1;
    repeat (4) tick();
    chk("rnd_idle", bus.idle, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
